timer_irq_ctrl: RTL and testbench

- Memory-mapped interval timer and interrupt controller on the peripheral bus at 0x40000000.
- Provides TH (reload), TL (counter) and TCON (control/status) registers.
- Drives the CPU interrupt request that vectors the program to its handler at 0x00000004.
- Sequences the software tasks: periodic 7-segment digit scan and UART result display, by raising periodic interrupts that software acknowledges through TCON.

---
 rtl/timer_irq_ctrl.sv | 132 +++++++++++++
 tb/tb_timer_irq_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_ctrl.sv
// ----------------------------------------------------------------------------
// timer_irq_ctrl
// Memory-mapped interval timer with a single level interrupt request.
//
// Register map (word addresses, addr[1:0] ignored):
//   BASE_ADDR + 0 : TH   reload value
//   BASE_ADDR + 4 : TL   free-running up counter
//   BASE_ADDR + 8 : TCON {pending, int_enable, timer_enable}
//
// Ports:
//   clk    in   system clock, all state changes on the rising edge
//   reset  in   synchronous active-high reset, highest priority
//   addr   in   32-bit byte address
//   wdata  in   32-bit write data
//   rd     in   read strobe (read data is combinational)
//   wr     in   write strobe, sampled on the rising edge
//   rdata  out  read data, zero when not reading a decoded register
//   irq    out  level interrupt request = TCON[1] & TCON[2]
// ----------------------------------------------------------------------------
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          TCON_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [29:0] TH_WORD   = BASE_ADDR[31:2];
  localparam logic [29:0] TL_WORD   = TH_WORD + 30'd1;
  localparam logic [29:0] TCON_WORD = TH_WORD + 30'd2;

  logic [31:0]       th_q,   th_d;
  logic [31:0]       tl_q,   tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;

  logic              sel_th_s;
  logic              sel_tl_s;
  logic              sel_tcon_s;
  logic              ovf_s;
  logic [TCON_W-1:0] tcon_set_s;
  logic              addr_lsb_unused_s;

  // Byte offset within a word carries no meaning for this block.
  assign addr_lsb_unused_s = ^addr[1:0];

  // Address decode on the word address only.
  always_comb begin
    sel_th_s   = (addr[31:2] == TH_WORD);
    sel_tl_s   = (addr[31:2] == TL_WORD);
    sel_tcon_s = (addr[31:2] == TCON_WORD);
  end

  // Overflow detection and status-set request, both from pre-write state.
  always_comb begin
    ovf_s         = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    tcon_set_s    = '0;
    if (ovf_s && tcon_q[1]) begin
      tcon_set_s[2] = 1'b1;
    end else begin
      tcon_set_s[2] = 1'b0;
    end
  end

  // Next-state: bus writes win over counting, except the pending set,
  // which is OR-ed in so a software clear cannot swallow an overflow.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;

    if (wr && sel_th_s) begin
      th_d = wdata;
    end else begin
      th_d = th_q;
    end

    // Reload uses th_q, so a same-cycle TH write affects only the next period.
    if (wr && sel_tl_s) begin
      tl_d = wdata;
    end else if (ovf_s) begin
      tl_d = th_q;
    end else if (tcon_q[0]) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end

    if (wr && sel_tcon_s) begin
      tcon_d = wdata[TCON_W-1:0] | tcon_set_s;
    end else begin
      tcon_d = tcon_q | tcon_set_s;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= 32'd0;
      tl_q   <= 32'd0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  // Combinational read mux; shows pre-write values when rd and wr coincide.
  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case ({sel_th_s, sel_tl_s, sel_tcon_s})
        3'b100:  rdata = th_q;
        3'b010:  rdata = tl_q;
        3'b001:  rdata = {{(32-TCON_W){1'b0}}, tcon_q};
        default: rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

  // Interrupt enable masks the request but leaves the pending bit intact.
  assign irq = tcon_q[1] & tcon_q[2];

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp;
  int n_fail;

  timer_irq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .rd    (rd),
    .wr    (wr),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_WR, OP_RD, OP_RDN, OP_IDLE, OP_RST} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] a;
    logic [31:0] d;     // write data, expected read data, or idle cycle count
    logic        irq_e; // expected irq on read ops
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic [31:0] a, logic [31:0] d, logic irq_e);
    vec_t v;
    v.op = op; v.a = a; v.d = d; v.irq_e = irq_e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1; rd = 1'b0;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic rden,
                        input logic [31:0] exp_d, input logic exp_irq);
    addr = a; rd = rden;
    #1;
    check({nm, "_rdata"}, rdata, exp_d);
    check({nm, "_irq"}, {31'd0, irq}, {31'd0, exp_irq});
    rd = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; addr = 32'd0; wdata = 32'd0; rd = 1'b0; wr = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state, then reset after arbitrary writes
    vecs.push_back(mk(OP_RD,   A_TH,   32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd0, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TH,   32'h0000_1234, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TL,   32'h0000_0055, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd3, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd2, 1'b0));
    vecs.push_back(mk(OP_RST,  32'd0,  32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TH,   32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd0, 1'b0));
    // Periodic interrupt
    vecs.push_back(mk(OP_WR,   A_TH,   32'hFFFF_FFFD, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TL,   32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd3, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd3, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd1, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFD, 1'b1));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd7, 1'b1));
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd3, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd3, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd1, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd1, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFD, 1'b1));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd7, 1'b1));
    // Interrupt disabled: reload without status
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd1, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd1, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd2, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFD, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd1, 1'b0));
    // Timer disabled: TL frozen
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd0, 1'b0));
    vecs.push_back(mk(OP_IDLE, 32'd0,  32'd10, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd0, 1'b0));
    // Masking keeps pending status
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd4, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd4, 1'b0));
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd6, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd6, 1'b1));
    vecs.push_back(mk(OP_WR,   A_TCON, 32'd4, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TCON, 32'd4, 1'b0));
    // Decode: undecoded addresses and rd=0
    vecs.push_back(mk(OP_WR,   32'h4000_000C, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_WR,   32'h4000_0020, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_WR,   32'h0000_0008, 32'd7, 1'b0));
    vecs.push_back(mk(OP_RD,   32'h4000_000C, 32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   32'h4000_0020, 32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   32'h0000_0008, 32'd0, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TH,   32'hFFFF_FFFD, 1'b0));
    vecs.push_back(mk(OP_RD,   A_TL,   32'hFFFF_FFFE, 1'b0));
    vecs.push_back(mk(OP_RD,   32'h4000_000A, 32'd4, 1'b0));
    vecs.push_back(mk(OP_RDN,  A_TH,   32'd0, 1'b0));

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:   do_wr(vecs[i].a, vecs[i].d);
        OP_RD:   rd_chk($sformatf("vec%0d", i), vecs[i].a, 1'b1, vecs[i].d, vecs[i].irq_e);
        OP_RDN:  rd_chk($sformatf("vec%0d", i), vecs[i].a, 1'b0, vecs[i].d, vecs[i].irq_e);
        OP_IDLE: for (int c = 0; c < int'(vecs[i].d); c++) tick();
        OP_RST:  begin reset = 1'b1; tick(); reset = 1'b0; end
        default: ;
      endcase
    end

    // Ack race: software rewrite of TCON=3 on the overflow edge
    do_wr(A_TCON, 32'd0);
    do_wr(A_TL, 32'hFFFF_FFFF);
    do_wr(A_TCON, 32'd3);
    rd_chk("race_pre_tl", A_TL, 1'b1, 32'hFFFF_FFFF, 1'b0);
    do_wr(A_TCON, 32'd3);
    rd_chk("race_tcon", A_TCON, 1'b1, 32'd7, 1'b1);
    rd_chk("race_tl", A_TL, 1'b1, 32'hFFFF_FFFD, 1'b1);

    // TL write on the overflow edge
    do_wr(A_TCON, 32'd3);
    tick();
    rd_chk("coll_pre_tl", A_TL, 1'b1, 32'hFFFF_FFFF, 1'b0);
    do_wr(A_TL, 32'h1234_5678);
    rd_chk("coll_tl_wr", A_TL, 1'b1, 32'h1234_5678, 1'b1);

    // TH write on the reload edge: reload uses old TH
    do_wr(A_TL, 32'hFFFF_FFFF);
    do_wr(A_TH, 32'd5);
    rd_chk("coll_th_tl", A_TL, 1'b1, 32'hFFFF_FFFD, 1'b1);
    rd_chk("coll_th_th", A_TH, 1'b1, 32'd5, 1'b1);
    tick(); tick(); tick();
    rd_chk("coll_new_th", A_TL, 1'b1, 32'd5, 1'b1);

    // rd and wr together show the pre-write value
    addr = A_TH; wdata = 32'hA5A5_A5A5; rd = 1'b1; wr = 1'b1;
    #1;
    check("rdwr_pre", rdata, 32'd5);
    tick();
    wr = 1'b0; rd = 1'b0;
    rd_chk("rdwr_post", A_TH, 1'b1, 32'hA5A5_A5A5, 1'b1);

    // Reset mid-count
    reset = 1'b1;
    tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    rd_chk("rst_th", A_TH, 1'b1, 32'd0, 1'b0);
    rd_chk("rst_tl", A_TL, 1'b1, 32'd0, 1'b0);
    rd_chk("rst_tcon", A_TCON, 1'b1, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
